// File: rtl/mmio_read_select_seq.sv
// Registered load-data path: decodes a CPU load into DMEM or one of NCH peripheral
// channels, strobes the channel, waits for ack or timeout, returns one word with rvalid.

module mmio_read_select_lane #(
  parameter int DW = 32
) (
  input  logic          sel,
  input  logic          ack,
  input  logic [DW-1:0] data,
  output logic          hit,
  output logic [DW-1:0] dout
);
  assign hit  = sel & ack;
  assign dout = sel ? data : '0;
endmodule

module mmio_read_select_seq #(
  parameter int              NCH         = 8,
  parameter int              AW          = 12,
  parameter int              DW          = 32,
  parameter logic [AW-1:0]   PERIPH_BASE = 12'h800,
  parameter int              STRIDE_LOG2 = 2,
  parameter int              TIMEOUT     = 15,
  parameter logic [DW-1:0]   ERR_DATA    = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     dmem_rdata,
  input  logic [NCH*DW-1:0] ch_rdata,
  input  logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_re,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] AMASK = {AW{1'b1}} >> (AW - STRIDE_LOG2);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_d;

  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [NCH-1:0] ch_re_d;
  logic [DW-1:0] rdata_d;
  logic rvalid_d, err_d;

  // Address decode: aligned, in range, upper half of the map
  logic [AW-1:0] off, idx_full;
  logic          hit;
  logic [IW-1:0] idx;
  assign off      = cpu_addr - PERIPH_BASE;
  assign idx_full = off >> STRIDE_LOG2;
  assign idx      = idx_full[IW-1:0];
  assign hit      = cpu_addr[AW-1] && (cpu_addr >= PERIPH_BASE) &&
                    ((off & AMASK) == '0) && (idx_full < AW'(NCH));

  // Per-channel select of ack/data for the latched channel
  logic [NCH-1:0]         lane_hit;
  logic [NCH-1:0][DW-1:0] lane_dout;
  logic                   ack_sel;
  logic [DW-1:0]          data_sel;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mmio_read_select_lane #(.DW(DW)) u_lane (
      .sel  (idx_q == IW'(k)),
      .ack  (ch_ack[k]),
      .data (ch_rdata[k*DW +: DW]),
      .hit  (lane_hit[k]),
      .dout (lane_dout[k])
    );
  end

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NCH; k++) data_sel = data_sel | lane_dout[k];
  end
  assign ack_sel = |lane_hit;

  assign busy = (state == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      cnt    <= '0;
      ch_re  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      idx_q  <= idx_d;
      cnt    <= cnt_d;
      ch_re  <= ch_re_d;
      rdata  <= rdata_d;
      rvalid <= rvalid_d;
      err    <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (cpu_re && hit) state_d = S_WAIT;
      S_WAIT: if (ack_sel || cnt == CW'(TIMEOUT)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_re_d  = '0;
    rvalid_d = 1'b0;
    rdata_d  = rdata;
    cnt_d    = cnt;
    idx_d    = idx_q;
    err_d    = err;
    case (state)
      S_IDLE: begin
        if (cpu_re) begin
          if (hit) begin
            idx_d = idx;
            cnt_d = CW'(1);
            for (int k = 0; k < NCH; k++) ch_re_d[k] = (idx == IW'(k));
          end else begin
            rdata_d  = dmem_rdata;
            rvalid_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Ack beats a coinciding timeout
        if (ack_sel) begin
          rdata_d  = data_sel;
          rvalid_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt == CW'(TIMEOUT)) begin
          rdata_d  = ERR_DATA;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: ;
    endcase
    if (err_clr) err_d = 1'b0;
  end
endmodule
